// File: rtl/alu_minmax_scanner.sv
// rtl/alu_minmax_scanner.sv - streaming signed min/max scanner built around one shared SGT comparator
module alu_minmax_scanner #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_max,
    output logic [N-1:0]     out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_CMP_MAX,
        S_CMP_MIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic [N-1:0]      r_max;
    logic [N-1:0]      r_min;
    logic [N-1:0]      r_hold;
    logic              r_hold_last;
    logic [CNT_W-1:0]  r_max_idx;
    logic [CNT_W-1:0]  r_min_idx;
    logic [CNT_W-1:0]  r_hold_idx;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_inc;

    logic [N-1:0]      w_cmp_a;
    logic [N-1:0]      w_cmp_b;
    logic [N-1:0]      w_diff;
    logic              w_gt;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Shared comparator: CMP_MAX asks gt(hold, max), CMP_MIN asks gt(min, hold).
    // B-A is trusted only when signs agree; otherwise the non-negative operand wins.
    assign w_cmp_a = (r_state == S_CMP_MAX) ? r_hold : r_min;
    assign w_cmp_b = (r_state == S_CMP_MAX) ? r_max  : r_hold;
    assign w_diff  = w_cmp_b - w_cmp_a;
    assign w_gt    = (w_cmp_a[N-1] == w_cmp_b[N-1]) ? w_diff[N-1] : ~w_cmp_a[N-1];

    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_ONE;

    assign in_ready   = rst_n && ((r_state == S_IDLE) || (r_state == S_ACCEPT));
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    assign out_max     = r_max;
    assign out_min     = r_min;
    assign out_max_idx = r_max_idx;
    assign out_min_idx = r_min_idx;
    assign out_count   = r_count;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_in_xfer) w_next = in_last ? S_DONE : S_ACCEPT;
            S_ACCEPT:  if (w_in_xfer) w_next = S_CMP_MAX;
            S_CMP_MAX: w_next = S_CMP_MIN;
            S_CMP_MIN: w_next = r_hold_last ? S_DONE : S_ACCEPT;
            S_DONE:    if (w_out_xfer) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_max       <= '0;
            r_min       <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_max_idx   <= '0;
            r_min_idx   <= '0;
            r_hold_idx  <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_max     <= in_data;
                        r_min     <= in_data;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_count   <= CNT_ONE;
                    end
                end
                S_ACCEPT: begin
                    if (w_in_xfer) begin
                        r_hold      <= in_data;
                        r_hold_last <= in_last;
                        r_hold_idx  <= r_count;
                        r_count     <= w_count_inc;
                    end
                end
                S_CMP_MAX: begin
                    if (w_gt) begin
                        r_max     <= r_hold;
                        r_max_idx <= r_hold_idx;
                    end
                end
                S_CMP_MIN: begin
                    if (w_gt) begin
                        r_min     <= r_hold;
                        r_min_idx <= r_hold_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_minmax_scanner.sv
// tb/tb_alu_minmax_scanner.sv - directed table-driven bench for alu_minmax_scanner
module tb_alu_minmax_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_max;
    logic [31:0] out_min;
    logic [15:0] out_max_idx;
    logic [15:0] out_min_idx;
    logic [15:0] out_count;
    logic        busy;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_max;
    logic [31:0] s_out_min;
    logic [2:0]  s_out_max_idx;
    logic [2:0]  s_out_min_idx;
    logic [2:0]  s_out_count;
    logic        s_busy;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    alu_minmax_scanner #(.N(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
        .out_min_idx(out_min_idx), .out_count(out_count), .busy(busy)
    );

    // Narrow-counter copy sharing the same input stream, used for saturation cases.
    alu_minmax_scanner #(.N(32), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_max(s_out_max), .out_min(s_out_min), .out_max_idx(s_out_max_idx),
        .out_min_idx(s_out_min_idx), .out_count(s_out_count), .busy(s_busy)
    );

    always @(posedge clk) if (in_valid && in_ready) xfers <= xfers + 1;

    typedef struct packed {
        logic [0:9][31:0] d;
        logic [3:0]       len;
        logic             gaps;
        logic             sat;
        logic [31:0]      emax;
        logic [31:0]      emin;
        logic [15:0]      emaxi;
        logic [15:0]      emini;
        logic [15:0]      ecnt;
    } vec_t;

    function automatic vec_t mkv(input logic [0:9][31:0] d, input int len, input bit gaps,
                                 input bit sat, input logic [31:0] emax, input logic [31:0] emin,
                                 input int emaxi, input int emini, input int ecnt);
        vec_t v;
        v.d = d; v.len = 4'(len); v.gaps = gaps; v.sat = sat;
        v.emax = emax; v.emin = emin;
        v.emaxi = 16'(emaxi); v.emini = 16'(emini); v.ecnt = 16'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_one(input logic [31:0] d, input logic last);
        int tries;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        tries = 0;
        while (!in_ready && tries < 20) begin @(negedge clk); tries++; end
        if (tries >= 20) chk("send_one_timeout", 64'(tries), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int start, neg, tries;
        logic r0, r1;
        start = xfers;
        for (int i = 0; i < int'(v.len); i++) begin
            @(negedge clk);
            if (v.gaps) begin
                repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(negedge clk); end
            end
            in_valid = 1'b1; in_data = v.d[i]; in_last = (i == int'(v.len) - 1);
            tries = 0;
            while (!in_ready && tries < 20) begin @(negedge clk); tries++; end
            chk({tag, "_accept_timeout"}, 64'(tries < 20), 64'd1);
            @(posedge clk);
            #1 in_valid = 1'b0; in_last = 1'b0;
            neg = 0;
            if (i > 0) begin
                @(negedge clk); r0 = in_ready;
                @(negedge clk); r1 = in_ready;
                neg = 2;
                chk({tag, "_ready_in_cmp"}, {62'd0, r0, r1}, 64'd0);
            end
            if (i == int'(v.len) - 1) begin
                do begin @(negedge clk); neg++; end while (!out_valid && neg < 20);
                chk({tag, "_latency"}, 64'(neg), (v.len > 1) ? 64'd3 : 64'd1);
            end
        end
        chk({tag, "_transfers"}, 64'(xfers - start), 64'(v.len));
        chk({tag, "_ready_in_done"}, 64'(in_ready), 64'd0);
        if (v.sat) begin
            chk({tag, "_max"}, 64'(s_out_max), 64'(v.emax));
            chk({tag, "_min"}, 64'(s_out_min), 64'(v.emin));
            chk({tag, "_max_idx"}, 64'(s_out_max_idx), 64'(v.emaxi));
            chk({tag, "_min_idx"}, 64'(s_out_min_idx), 64'(v.emini));
            chk({tag, "_count"}, 64'(s_out_count), 64'(v.ecnt));
        end else begin
            chk({tag, "_max"}, 64'(out_max), 64'(v.emax));
            chk({tag, "_min"}, 64'(out_min), 64'(v.emin));
            chk({tag, "_max_idx"}, 64'(out_max_idx), 64'(v.emaxi));
            chk({tag, "_min_idx"}, 64'(out_min_idx), 64'(v.emini));
            chk({tag, "_count"}, 64'(out_count), 64'(v.ecnt));
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_post_out"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    vec_t vecs [6];
    vec_t one;

    initial begin
        vecs[0] = mkv({32'd5, 32'hFFFFFFFD, 32'd7, 32'd7, 32'hFFFFFFFD, 160'd0},
                      5, 0, 0, 32'd7, 32'hFFFFFFFD, 2, 1, 5);
        vecs[1] = mkv({32'h7FFFFFFF, 32'h80000000, 256'd0},
                      2, 0, 0, 32'h7FFFFFFF, 32'h80000000, 0, 1, 2);
        vecs[2] = mkv({32'd1, 32'd2, 32'd3, 32'd4, 192'd0},
                      4, 1, 0, 32'd4, 32'd1, 3, 0, 4);
        vecs[3] = mkv({32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 224'd0},
                      3, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFB, 0, 0, 3);
        vecs[4] = mkv({32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 192'd0},
                      4, 1, 0, 32'h7FFFFFFF, 32'h80000000, 1, 0, 4);
        vecs[5] = mkv({32'd3, 32'hFFFFFFF8, 32'd5, 32'hFFFFFFF8, 32'd0, 32'd0, 32'd0, 32'd0,
                       32'd0, 32'h40000000},
                      10, 0, 1, 32'h40000000, 32'hFFFFFFF8, 7, 1, 7);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd0);
        chk("reset_data", {out_max, out_min}, 64'd0);
        chk("reset_idx", {out_max_idx, out_min_idx, out_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {62'd0, in_ready, busy}, 64'b10);

        for (int k = 0; k < 6; k++) begin
            run_vec($sformatf("vec%0d", k), vecs[k]);
            release_out($sformatf("vec%0d", k));
        end

        // Single element, then hold the result under back-pressure.
        one = mkv({32'hFFFFFFFF, 288'd0}, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1);
        run_vec("single", one);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("single_hold_ctrl", {62'd0, out_valid, in_ready}, 64'b10);
            chk("single_hold_data", {out_max, out_min}, {32'hFFFFFFFF, 32'hFFFFFFFF});
            chk("single_hold_idx", {out_max_idx, out_min_idx, out_count}, 64'd1);
        end
        release_out("single");

        // Asynchronous reset while element 2 sits in CMP_MIN.
        send_one(32'd10, 1'b0);
        send_one(32'hFFFFFFFC, 1'b0);
        send_one(32'd33, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("midscan_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midscan_rst_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd0);
        chk("midscan_rst_data", {out_max, out_min}, 64'd0);
        chk("midscan_rst_idx", {out_max_idx, out_min_idx, out_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        one = mkv({32'd9, 288'd0}, 1, 0, 0, 32'd9, 32'd9, 0, 0, 1);
        run_vec("after_rst", one);
        release_out("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_minmax_scanner.md
Name: alu_minmax_scanner

Overview:
- Multi-cycle scheduler around one shared 32-bit signed-greater-than comparator (SUB-based SGT) in the ALU32 area.
- Accepts a stream of signed operands over a valid/ready handshake and returns the signed maximum, the signed minimum, their first-occurrence indices and the element count.
- The single comparator is time-multiplexed: one max compare, then one min compare per element.
- Used for reduction instructions and for lab test harnesses.

Parameters:
- N, 32, operand width in bits (two's complement).
- CNT_W, 16, width of the count and index outputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  N  signed operand.
- in_last  input  1  marks the final element of a stream.
- out_valid  output  1  result registers hold a completed scan.
- out_ready  input  1  consumer accepts the result.
- out_max  output  N  signed maximum.
- out_min  output  N  signed minimum.
- out_max_idx  output  CNT_W  index of first occurrence of the max (0-based).
- out_min_idx  output  CNT_W  index of first occurrence of the min.
- out_count  output  CNT_W  number of elements scanned.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n=0 at any time, including mid-scan, immediately forces:
  - state to IDLE;
  - all data, index, count and hold registers to 0;
  - out_valid=0, busy=0, in_ready=0 while rst_n=0, then in_ready=1 in IDLE.
- Handshakes:
  - An input transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both 1 at a rising edge.
  - Result outputs are stable while out_valid=1.
- Comparator:
  - One instance only. gt(A,B) is exact signed A>B over the full range.
  - The sign of B−A gives the result only when the signs of A and B agree. When the signs differ, the result is 1 iff A is non-negative. This corrects for subtraction overflow.
- FSM states: IDLE, ACCEPT, CMP_MAX, CMP_MIN, DONE.
- IDLE: in_ready=1. On transfer:
  - max=min=in_data; max_idx=min_idx=0; count=1.
  - Go to DONE if in_last, else ACCEPT.
- ACCEPT: in_ready=1. On transfer:
  - hold=in_data; hold_last=in_last; hold_idx=count.
  - count increments, saturating at 2^CNT_W−1.
  - Go to CMP_MAX.
- CMP_MAX: in_ready=0; comparator computes gt(hold, max).
  - If 1: max=hold, max_idx=hold_idx.
  - Always go to CMP_MIN.
- CMP_MIN: in_ready=0; comparator computes gt(min, hold).
  - If 1: min=hold, min_idx=hold_idx.
  - Go to DONE if hold_last, else ACCEPT.
- DONE: out_valid=1, in_ready=0. On output transfer, go to IDLE with out_valid=0 at the next cycle. Registers keep their values until the next first element.
- Timing:
  - Throughput is 3 cycles per element after the first.
  - Latency from accepting the last element (count>1) to out_valid is 2 cycles. For a single-element stream it is 1 cycle.
- Ties: strict greater-than, so equal values never replace the stored value and the earliest index is retained.
- Saturation: count and hold_idx saturate at all-ones. Values are still compared; indices beyond saturation report all-ones.
- No simultaneous accept and result: in_ready=0 whenever out_valid=1.

Test Plan:
1. Reset then stream {5, −3, 7, 7, −3(last)} → out_max=7, out_max_idx=2, out_min=−3, out_min_idx=1, out_count=5; out_valid rises 2 cycles after the last accept.
2. Overflow corner: stream {0x7FFFFFFF, 0x80000000(last)} → out_max=0x7FFFFFFF idx 0, out_min=0x80000000 idx 1. This confirms the corrected comparison; naive subtraction would swap them.
3. Single element {−1(last)} → out_max=out_min=0xFFFFFFFF, both idx 0, count=1, out_valid 1 cycle after the accept; hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
4. Back-pressure and gaps: in_valid toggled randomly, element stream {1,2,3,4(last)} → exactly 4 transfers; in_ready is 0 in CMP_MAX/CMP_MIN; max=4 idx 3, min=1 idx 0.
5. Reset mid-scan: assert rst_n=0 during CMP_MIN of element 2 → all outputs 0 asynchronously. After release, a new stream {9(last)} → max=min=9, count=1.
6. Saturation with CNT_W=3: 10-element stream with max at index 9 → out_count=7, out_max_idx=7, max value correct.
